// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Owner encoding is used by the picker and the optional MEM_ARB_RR_EN last-owner register.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; the caches and memory model together use master.
interface mem_arb_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int unsigned LINE_W = mem_arb_pkg::LINE_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant picker. MEM_ARB_RR_EN selects round-robin on conflict;
// otherwise the D-cache wins every conflict.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_own_i,
  output owner_e own_o,
  output logic   valid_o
);

  always_comb begin
    valid_o = i_req_i | d_req_i;
    own_o   = d_req_i ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
    if (i_req_i && d_req_i) begin
      own_o = (last_own_i == OWN_D) ? OWN_I : OWN_D;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  // D miss belongs to the older instruction, so fixed priority needs no history.
  logic unused_last_own;
  assign unused_last_own = last_own_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line requests onto one memory port with registered
// memory fields and a one-cycle done pulse. MEM_ARB_RR_EN enables round-robin conflicts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input logic      clk,
  input logic      reset,
  mem_arb_if.slave bus
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

  owner_e            last_own;
  owner_e            pick_own;
  logic              pick_valid;

`ifdef MEM_ARB_RR_EN
  owner_e last_own_q, last_own_d;
  assign last_own = last_own_q;
`else
  assign last_own = OWN_D;
`endif

  mem_arb_pick u_pick (
    .i_req_i    (bus.i_req),
    .d_req_i    (bus.d_req),
    .last_own_i (last_own),
    .own_o      (pick_own),
    .valid_o    (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_own_d  = last_own_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          mem_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_own_d = pick_own;
`endif
          if (pick_own == OWN_I) begin
            mem_addr_d  = bus.i_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            state_d     = BUSY_I;
          end else begin
            mem_addr_d  = bus.d_addr;
            mem_we_d    = bus.d_we;
            mem_wdata_d = bus.d_wdata;
            state_d     = BUSY_D;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          i_rdata_d = bus.mem_rdata;
          i_done_d  = 1'b1;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          // Write-backs leave the last read line visible to the D-cache.
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          d_done_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_own_q  <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
`ifdef MEM_ARB_RR_EN
      last_own_q  <= last_own_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory transactions and done responses are queued
// at issue time and popped when the DUT raises mem_req or a done pulse.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  typedef logic [AW-1:0] addr_t;
  typedef logic [LW-1:0] line_t;

  typedef struct {
    logic  we;
    addr_t addr;
    line_t wdata;
    line_t rdata;
    int    cyc;
  } mem_exp_t;

  typedef struct {
    line_t rdata;
    int    cyc;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset;

  mem_arb_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        mem_delay = 0;
  int        mem_cnt  = 0;
  bit        mem_busy = 1'b0;
  line_t     mem_ret  = '0;
  line_t     d_model  = '0;
  mem_exp_t  mem_q[$];
  done_exp_t i_q[$];
  done_exp_t d_q[$];

  task automatic check_eq(input string tag, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: memory model responds, done monitor pops the scoreboard and drops req.
  task automatic step();
    mem_exp_t  m;
    done_exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_ready = 1'b0;
    if (bus.mem_req && !mem_busy) begin
      if (mem_q.size() == 0) begin
        check_eq("mem_req_unexpected", line_t'(bus.mem_req), '0);
      end else begin
        m = mem_q.pop_front();
        check_eq("mem_we", line_t'(bus.mem_we), line_t'(m.we));
        check_eq("mem_addr", line_t'(bus.mem_addr), line_t'(m.addr));
        check_eq("mem_wdata", bus.mem_wdata, m.wdata);
        check_eq("mem_req_cycle", line_t'(cyc), line_t'(m.cyc));
        mem_ret  = m.rdata;
        mem_busy = 1'b1;
        mem_cnt  = 0;
      end
    end
    if (mem_busy) begin
      if (mem_cnt == mem_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_ret;
        mem_busy      = 1'b0;
      end else begin
        mem_cnt++;
      end
    end
    if (bus.i_done) begin
      if (i_q.size() == 0) begin
        check_eq("i_done_unexpected", line_t'(bus.i_done), '0);
      end else begin
        e = i_q.pop_front();
        check_eq("i_rdata", bus.i_rdata, e.rdata);
        check_eq("i_done_cycle", line_t'(cyc), line_t'(e.cyc));
      end
      bus.i_req = 1'b0;
    end
    if (bus.d_done) begin
      if (d_q.size() == 0) begin
        check_eq("d_done_unexpected", line_t'(bus.d_done), '0);
      end else begin
        e = d_q.pop_front();
        check_eq("d_rdata", bus.d_rdata, e.rdata);
        check_eq("d_done_cycle", line_t'(cyc), line_t'(e.cyc));
      end
      bus.d_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((mem_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0 || bus.busy) && n < max) begin
      step();
      n++;
    end
    check_eq("drain", line_t'(mem_q.size() + i_q.size() + d_q.size() + int'(bus.busy)), '0);
  endtask

  task automatic push_i(input addr_t a, input line_t rd, input int mc, input int dc);
    mem_q.push_back('{we: 1'b0, addr: a, wdata: '0, rdata: rd, cyc: mc});
    i_q.push_back('{rdata: rd, cyc: dc});
  endtask

  task automatic push_d(input logic we, input addr_t a, input line_t wd, input line_t rd,
                        input int mc, input int dc);
    mem_q.push_back('{we: we, addr: a, wdata: wd, rdata: rd, cyc: mc});
    if (!we) d_model = rd;
    d_q.push_back('{rdata: d_model, cyc: dc});
  endtask

  task automatic single_i(input addr_t a, input line_t rd, input int n);
    mem_delay = n;
    push_i(a, rd, cyc + 1, cyc + 2 + n);
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    wait_idle(40);
  endtask

  task automatic single_d(input logic we, input addr_t a, input line_t wd, input line_t rd,
                          input int n);
    mem_delay = n;
    push_d(we, a, wd, rd, cyc + 1, cyc + 2 + n);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    wait_idle(40);
  endtask

  // Both requests rise together; d_first selects the expected grant order.
  task automatic conflict(input bit d_first, input addr_t ia, input line_t ird, input addr_t da,
                          input line_t drd, input int n);
    int c0 = cyc;
    mem_delay = n;
    if (d_first) begin
      push_d(1'b0, da, '0, drd, c0 + 1, c0 + 2 + n);
      push_i(ia, ird, c0 + 4 + n, c0 + 5 + 2 * n);
    end else begin
      push_i(ia, ird, c0 + 1, c0 + 2 + n);
      push_d(1'b0, da, '0, drd, c0 + 4 + n, c0 + 5 + 2 * n);
    end
    bus.i_addr  = ia;
    bus.i_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = da;
    bus.d_wdata = '0;
    bus.d_req   = 1'b1;
    wait_idle(60);
  endtask

  line_t a5_line;
  line_t pat_a;
  line_t pat_b;
  line_t pat_c;
  line_t pat_d;
  bit    rr_en;

  initial begin
`ifdef MEM_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    a5_line = {16{8'hA5}};
    pat_a   = {4{32'h0BAD_CAFE}};
    pat_b   = {4{32'h1357_9BDF}};
    pat_c   = {4{32'h2468_ACE0}};
    pat_d   = {4{32'hF00D_0001}};

    reset         = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    check_eq("rst_mem_req", line_t'(bus.mem_req), '0);
    check_eq("rst_mem_we", line_t'(bus.mem_we), '0);
    check_eq("rst_i_done", line_t'(bus.i_done), '0);
    check_eq("rst_d_done", line_t'(bus.d_done), '0);
    check_eq("rst_busy", line_t'(bus.busy), '0);
    check_eq("rst_mem_addr", line_t'(bus.mem_addr), '0);
    check_eq("rst_mem_wdata", bus.mem_wdata, '0);
    check_eq("rst_i_rdata", bus.i_rdata, '0);
    check_eq("rst_d_rdata", bus.d_rdata, '0);
    reset = 1'b0;
    step();

    single_i(32'h100, a5_line, 3);
    step();
    check_eq("i_rdata_hold", bus.i_rdata, a5_line);

    single_d(1'b0, 32'h3000, '0, pat_a, 1);
    single_d(1'b1, 32'h2040, line_t'(32'h1234), '0, 2);
    check_eq("d_rdata_after_wb", bus.d_rdata, pat_a);

    // Last owner is D here, so round-robin hands the first conflict to I.
    conflict(!rr_en, 32'h400, pat_b, 32'h500, pat_c, 2);
    single_i(32'hA00, pat_d, 1);
    conflict(1'b1, 32'h440, pat_a, 32'h540, pat_b, 1);

    single_i(32'h600, pat_c, 0);

    // Asynchronous reset while serving the D-cache.
    mem_delay = 10;
    push_d(1'b0, 32'h700, '0, pat_d, cyc + 1, cyc + 12);
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h700;
    bus.d_req  = 1'b1;
    step();
    step();
    check_eq("pre_rst_mem_req", line_t'(bus.mem_req), line_t'(1));
    check_eq("pre_rst_d_rdata", bus.d_rdata, pat_b);
    reset = 1'b1;
    #1;
    check_eq("arst_mem_req", line_t'(bus.mem_req), '0);
    check_eq("arst_busy", line_t'(bus.busy), '0);
    check_eq("arst_d_rdata", bus.d_rdata, '0);
    check_eq("arst_mem_addr", line_t'(bus.mem_addr), '0);
    d_q.delete();
    mem_q.delete();
    mem_busy  = 1'b0;
    d_model   = '0;
    bus.d_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    single_i(32'h800, pat_a, 1);

    // Request inputs moving mid-transaction must not reach memory.
    mem_delay = 3;
    push_i(32'h900, pat_b, cyc + 1, cyc + 5);
    bus.i_addr = 32'h900;
    bus.i_req  = 1'b1;
    step();
    step();
    bus.i_addr = 32'hDEAD;
    step();
    check_eq("mem_addr_latched", line_t'(bus.mem_addr), line_t'(32'h900));
    wait_idle(40);

    step();
    bus.mem_ready = 1'b1;
    step();
    step();
    check_eq("stray_ready_done", line_t'({bus.i_done, bus.d_done}), '0);
    check_eq("stray_ready_busy", line_t'(bus.busy), '0);
    check_eq("stray_ready_mem_req", line_t'(bus.mem_req), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
